// File: rtl/types_pkg.sv
// Shared display types: digit count, segment byte, and the scanner's state encoding.
package types_pkg;

  localparam int DIGITS = 8;

  typedef logic [7:0] byte_t;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg_display_scan.sv
// Multiplexed seven-segment scanner: snapshots the per-digit cathode bus once per frame,
// then walks the digits with an all-off blanking gap before each drive slot.
module seg_display_scan
  import types_pkg::*;
#(
  parameter int DIGITS       = types_pkg::DIGITS,
  parameter int DWELL_CYCLES = 100_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DIGITS*8-1:0] display,
  input  logic [DIGITS-1:0]   digit_en,
  output logic [DIGITS-1:0]   anode,
  output byte_t               cathode,
  output logic                frame_start
);

  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam scan_state_t   SLOT_ENTRY = (BLANK_CYCLES > 0) ? BLANK : DRIVE;

  generate
    if (DWELL_CYCLES < 1) begin : g_bad_dwell
      $error("seg_display_scan: DWELL_CYCLES must be at least 1");
    end
    if (BLANK_CYCLES < 0) begin : g_bad_blank
      $error("seg_display_scan: BLANK_CYCLES must not be negative");
    end
    if (DIGITS < 1) begin : g_bad_digits
      $error("seg_display_scan: DIGITS must be at least 1");
    end
  endgenerate

  scan_state_t         state_reg, state_next;
  logic [IW-1:0]       idx_reg, idx_next;
  logic [CW-1:0]       cnt_reg, cnt_next;
  logic                run_reg;
  logic                load;
  logic [DIGITS*8-1:0] snap_disp_reg, snap_disp_next;
  logic [DIGITS-1:0]   snap_en_reg, snap_en_next;
  logic [DIGITS-1:0]   anode_reg, anode_next;
  byte_t               cathode_reg, cathode_next;
  logic                frame_start_reg;
  byte_t               disp_bytes [DIGITS];

  // run_reg is clear only straight after reset, so the first live edge enters digit 0
  // exactly like a frame wrap does, taking the snapshot on that same edge.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    load       = 1'b0;
    if (!run_reg) begin
      state_next = SLOT_ENTRY;
      idx_next   = '0;
      cnt_next   = '0;
      load       = 1'b1;
    end else if (state_reg == BLANK) begin
      if (cnt_reg == BLANK_LAST) begin
        state_next = DRIVE;
        cnt_next   = '0;
      end else begin
        cnt_next = cnt_reg + CW'(1);
      end
    end else begin
      if (cnt_reg == DWELL_LAST) begin
        state_next = SLOT_ENTRY;
        cnt_next   = '0;
        if (idx_reg == IDX_LAST) begin
          idx_next = '0;
          load     = 1'b1;
        end else begin
          idx_next = idx_reg + IW'(1);
        end
      end else begin
        cnt_next = cnt_reg + CW'(1);
      end
    end
  end

  assign snap_disp_next = load ? display  : snap_disp_reg;
  assign snap_en_next   = load ? digit_en : snap_en_reg;

  // Outputs are decoded from the next state so the pins line up with the state registers.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign disp_bytes[gi] = snap_disp_next[gi*8 +: 8];
      assign anode_next[gi] = !((state_next == DRIVE) && (idx_next == IW'(gi)) && snap_en_next[gi]);
    end
  endgenerate

  assign cathode_next = (state_next == DRIVE) ? disp_bytes[idx_next] : 8'hFF;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= BLANK;
      idx_reg         <= '0;
      cnt_reg         <= '0;
      run_reg         <= 1'b0;
      snap_disp_reg   <= '1;
      snap_en_reg     <= '0;
      anode_reg       <= '1;
      cathode_reg     <= 8'hFF;
      frame_start_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      cnt_reg         <= cnt_next;
      run_reg         <= 1'b1;
      snap_disp_reg   <= snap_disp_next;
      snap_en_reg     <= snap_en_next;
      anode_reg       <= anode_next;
      cathode_reg     <= cathode_next;
      frame_start_reg <= load;
    end
  end

  assign anode       = anode_reg;
  assign cathode     = cathode_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_seg_display_scan.sv
// Bench for seg_display_scan: a 4-digit blanking instance and a 4-digit zero-blank instance,
// checked every cycle against a frame-position model plus literal waveform points.
module tb_seg_display_scan;

  localparam int BA = 2;
  localparam int WA = 3;
  localparam int BB = 0;
  localparam int WB = 3;

  logic        clk = 1'b0;
  logic        rst_a = 1'b0, rst_b = 1'b0;
  logic [31:0] display_a = '1, display_b = '1;
  logic [3:0]  en_a = '0, en_b = '0;
  logic [3:0]  anode_a, anode_b;
  logic [7:0]  cathode_a, cathode_b;
  logic        fs_a, fs_b;

  int n_cmp = 0;
  int n_bad = 0;

  // model state: edges since release and the frame snapshot taken by the model itself
  int          t_a = 0, t_b = 0;
  logic [31:0] sd_a = '1, sd_b = '1;
  logic [3:0]  se_a = '0, se_b = '0;
  logic [3:0]  ea_an, eb_an;
  logic [7:0]  ea_ca, eb_ca;
  logic        ea_fs, eb_fs;

  always #5 clk = ~clk;

  seg_display_scan #(.DIGITS(4), .DWELL_CYCLES(WA), .BLANK_CYCLES(BA)) dut_a (
    .clk(clk), .rst(rst_a), .display(display_a), .digit_en(en_a),
    .anode(anode_a), .cathode(cathode_a), .frame_start(fs_a)
  );

  seg_display_scan #(.DIGITS(4), .DWELL_CYCLES(WB), .BLANK_CYCLES(BB)) dut_b (
    .clk(clk), .rst(rst_b), .display(display_b), .digit_en(en_b),
    .anode(anode_b), .cathode(cathode_b), .frame_start(fs_b)
  );

  // Expected pins after edge t of a running scan: position within the frame picks the slot.
  function automatic void model(input int t, input int b, input int w, input logic [31:0] sd,
                                input logic [3:0] se, output logic [3:0] an,
                                output logic [7:0] ca, output logic fs);
    int pos, k, off;
    an = 4'hF;
    ca = 8'hFF;
    fs = 1'b0;
    if (t == 0) return;
    pos = (t - 1) % (4 * (b + w));
    k   = pos / (b + w);
    off = pos % (b + w);
    fs  = (pos == 0);
    if (off >= b) begin
      ca    = sd[k*8 +: 8];
      an[k] = ~se[k];
    end
  endfunction

  task automatic step_a();
    @(posedge clk);
    if (!rst_a) begin
      t_a = 0; sd_a = '1; se_a = '0;
    end else begin
      t_a++;
      if ((t_a - 1) % (4 * (BA + WA)) == 0) begin
        sd_a = display_a; se_a = en_a;
      end
    end
    model(t_a, BA, WA, sd_a, se_a, ea_an, ea_ca, ea_fs);
    @(negedge clk);
  endtask

  task automatic step_b();
    @(posedge clk);
    if (!rst_b) begin
      t_b = 0; sd_b = '1; se_b = '0;
    end else begin
      t_b++;
      if ((t_b - 1) % (4 * (BB + WB)) == 0) begin
        sd_b = display_b; se_b = en_b;
      end
    end
    model(t_b, BB, WB, sd_b, se_b, eb_an, eb_ca, eb_fs);
    @(negedge clk);
  endtask

  task automatic restart_a(input logic [31:0] d, input logic [3:0] en);
    rst_a = 1'b0;
    step_a();
    display_a = d;
    en_a      = en;
    rst_a     = 1'b1;
  endtask

  task automatic test_reset();
    rst_a = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step_a();
      n_cmp++;
      if (anode_a !== 4'b1111 || cathode_a !== 8'hFF || fs_a !== 1'b0) begin
        n_bad++;
        $display("FAIL reset cyc %0d: got an=%b ca=%h fs=%b, want 1111 ff 0", c, anode_a, cathode_a, fs_a);
      end
    end
  endtask

  task automatic test_basic_scan();
    display_a = 32'hA4F9_C092;
    en_a      = 4'hF;
    rst_a     = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      step_a();
      n_cmp++;
      if (anode_a !== ea_an || cathode_a !== ea_ca || fs_a !== ea_fs) begin
        n_bad++;
        $display("FAIL basic edge %0d: got an=%b ca=%h fs=%b, want %b %h %b",
                 e, anode_a, cathode_a, fs_a, ea_an, ea_ca, ea_fs);
      end
      n_cmp++;
      if (fs_a !== (e == 1 || e == 21)) begin
        n_bad++;
        $display("FAIL basic_fs edge %0d: got fs=%b", e, fs_a);
      end
      if (e >= 3 && e <= 5) begin
        n_cmp++;
        if (anode_a !== 4'b1110 || cathode_a !== 8'h92) begin
          n_bad++;
          $display("FAIL basic_d0 edge %0d: got an=%b ca=%h, want 1110 92", e, anode_a, cathode_a);
        end
      end
      if (e == 6 || e == 7) begin
        n_cmp++;
        if (anode_a !== 4'b1111 || cathode_a !== 8'hFF) begin
          n_bad++;
          $display("FAIL basic_blank edge %0d: got an=%b ca=%h, want 1111 ff", e, anode_a, cathode_a);
        end
      end
      if (e >= 8 && e <= 10) begin
        n_cmp++;
        if (anode_a !== 4'b1101 || cathode_a !== 8'hC0) begin
          n_bad++;
          $display("FAIL basic_d1 edge %0d: got an=%b ca=%h, want 1101 c0", e, anode_a, cathode_a);
        end
      end
    end
  endtask

  task automatic test_snapshot();
    restart_a(32'hA4F9_C092, 4'hF);
    for (int e = 1; e <= 25; e++) begin
      step_a();
      if (e == 4) display_a = 32'hFFFF_FF80;
      n_cmp++;
      if (anode_a !== ea_an || cathode_a !== ea_ca || fs_a !== ea_fs) begin
        n_bad++;
        $display("FAIL snapshot edge %0d: got an=%b ca=%h fs=%b, want %b %h %b",
                 e, anode_a, cathode_a, fs_a, ea_an, ea_ca, ea_fs);
      end
      if ((e >= 3 && e <= 5) || (e >= 23 && e <= 25)) begin
        n_cmp++;
        if (anode_a !== 4'b1110 || cathode_a !== ((e < 21) ? 8'h92 : 8'h80)) begin
          n_bad++;
          $display("FAIL snapshot_d0 edge %0d: got an=%b ca=%h", e, anode_a, cathode_a);
        end
      end
    end
  endtask

  task automatic test_disable();
    restart_a($urandom, 4'b1011);
    for (int e = 1; e <= 40; e++) begin
      step_a();
      n_cmp++;
      if (anode_a !== ea_an || cathode_a !== ea_ca || fs_a !== ea_fs) begin
        n_bad++;
        $display("FAIL disable edge %0d: got an=%b ca=%h fs=%b, want %b %h %b",
                 e, anode_a, cathode_a, fs_a, ea_an, ea_ca, ea_fs);
      end
      if ((e >= 13 && e <= 15) || (e >= 33 && e <= 35)) begin
        n_cmp++;
        if (anode_a !== 4'b1111) begin
          n_bad++;
          $display("FAIL disable_d2 edge %0d: got an=%b, want 1111", e, anode_a);
        end
      end
      if (e >= 18 && e <= 20) begin
        n_cmp++;
        if (anode_a !== 4'b0111) begin
          n_bad++;
          $display("FAIL disable_d3 edge %0d: got an=%b, want 0111", e, anode_a);
        end
      end
    end
  endtask

  task automatic test_random();
    restart_a($urandom, 4'($urandom));
    for (int e = 1; e <= 160; e++) begin
      step_a();
      if ($urandom_range(0, 3) == 0) begin
        display_a = $urandom;
        en_a      = 4'($urandom);
      end
      n_cmp++;
      if (anode_a !== ea_an || cathode_a !== ea_ca || fs_a !== ea_fs) begin
        n_bad++;
        $display("FAIL random edge %0d: got an=%b ca=%h fs=%b, want %b %h %b",
                 e, anode_a, cathode_a, fs_a, ea_an, ea_ca, ea_fs);
      end
      n_cmp++;
      if ($countones(~anode_a) > 1) begin
        n_bad++;
        $display("FAIL random_onehot edge %0d: got an=%b, want at most one low", e, anode_a);
      end
    end
  endtask

  task automatic test_midframe_reset();
    logic [31:0] d;
    d = $urandom;
    restart_a(d, 4'hF);
    for (int e = 1; e <= 9; e++) step_a();
    rst_a = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step_a();
      n_cmp++;
      if (anode_a !== 4'b1111 || cathode_a !== 8'hFF || fs_a !== 1'b0) begin
        n_bad++;
        $display("FAIL midreset cyc %0d: got an=%b ca=%h fs=%b, want 1111 ff 0", c, anode_a, cathode_a, fs_a);
      end
    end
    d = $urandom;
    display_a = d;
    rst_a     = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step_a();
      n_cmp++;
      if (anode_a !== ea_an || cathode_a !== ea_ca || fs_a !== ea_fs) begin
        n_bad++;
        $display("FAIL restart edge %0d: got an=%b ca=%h fs=%b, want %b %h %b",
                 e, anode_a, cathode_a, fs_a, ea_an, ea_ca, ea_fs);
      end
      if (e == 1 || e == 3) begin
        n_cmp++;
        if (fs_a !== (e == 1) || anode_a !== ((e == 3) ? 4'b1110 : 4'b1111)) begin
          n_bad++;
          $display("FAIL restart_d0 edge %0d: got an=%b fs=%b", e, anode_a, fs_a);
        end
      end
    end
  endtask

  task automatic test_zero_blank();
    logic [3:0] want;
    rst_a     = 1'b0;
    display_b = $urandom;
    en_b      = 4'hF;
    rst_b     = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      step_b();
      if (e == 14) display_b = $urandom;
      n_cmp++;
      if (anode_b !== eb_an || cathode_b !== eb_ca || fs_b !== eb_fs) begin
        n_bad++;
        $display("FAIL zero_blank edge %0d: got an=%b ca=%h fs=%b, want %b %h %b",
                 e, anode_b, cathode_b, fs_b, eb_an, eb_ca, eb_fs);
      end
      want = ~(4'b0001 << (((e - 1) / 3) % 4));
      n_cmp++;
      if (anode_b !== want || fs_b !== ((e - 1) % 12 == 0)) begin
        n_bad++;
        $display("FAIL zero_blank_seq edge %0d: got an=%b fs=%b, want %b %b",
                 e, anode_b, fs_b, want, ((e - 1) % 12 == 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_snapshot();
    test_disable();
    test_random();
    test_midframe_reset();
    test_zero_blank();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_display_scan.md
# seg_display_scan

Time-multiplexed scanner that drives the physical multi-digit seven-segment display from the flattened per-digit cathode bus produced by the calculator display path (8 bits per digit, digit 0 in bits [7:0]). It snapshots the bus once per frame to prevent tearing, then cycles through the digits. Each digit gets a blanking interval (anti-ghosting) followed by a drive interval on a shared cathode bus with one active-low anode. It sits between the display-pattern generator and the board pins.

## Interface
- DIGITS, types_pkg::DIGITS (8): number of digits scanned.
- DWELL_CYCLES, 100_000: clock cycles each digit is driven; must be ≥1.
- BLANK_CYCLES, 1_000: clock cycles of all-off before each digit; 0 disables blanking.

Ports:
- clk  input  1  sole clock.
- rst  input  1  reset; synchronous, active-low (0 = reset, sampled on rising clk).
- display  input  DIGITS*8  per-digit cathode patterns, active-low segments, byte i = digit i; passed through unmodified.
- digit_en  input  DIGITS  per-digit enable; a disabled digit keeps its anode high during its drive slot.
- anode  output  DIGITS  active-low digit select; at most one bit low at any time.
- cathode  output  8 (byte_t)  segment pattern for the currently selected digit; 8'hFF when blank.
- frame_start  output  1  one-cycle pulse marking the snapshot capture of a new frame.

## Operation
- States: BLANK, DRIVE. Registers: state, digit index idx (0..DIGITS-1), cycle counter cnt, snapshot of display and digit_en.
- Reset (rst=0 on an edge): state=BLANK, idx=0, cnt=0, anode all 1, cathode 8'hFF, frame_start=0, snapshot display all-FF, snapshot digit_en all-0.
- Entering BLANK with idx=0 (including the first edge after reset release) loads the snapshot from display and digit_en, and pulses frame_start.
- BLANK: anode all 1, cathode 8'hFF. After BLANK_CYCLES cycles, go to DRIVE and clear cnt.
- DRIVE: anode[idx] = ~snap_en[idx], other anode bits 1, cathode = snap_display[idx*8+:8]. After DWELL_CYCLES cycles:
  - advance idx; wrap from DIGITS-1 to 0;
  - go to BLANK; when BLANK_CYCLES=0, go directly to DRIVE of the next digit.
- With BLANK_CYCLES=0, the snapshot and frame_start occur on the edge where idx wraps to 0.
- display and digit_en changes mid-frame are ignored until the next snapshot.
- Disabled digit: its slot timing is unchanged; anode stays high; cathode still shows its byte, which is harmless.
- Reset asserted mid-frame: on the next edge, all outputs take their reset values; scanning restarts from digit 0.
- cnt width: $clog2(max(DWELL_CYCLES, BLANK_CYCLES)+1). cnt compares to the parameter minus 1; no overflow possible.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Edge 1 is the first edge with rst sampled 1.
- frame_start is high from edge 1 to edge 2.
- Digit k drive spans edges 1+BLANK+k*(BLANK+DWELL) through the following DWELL edges.
- Frame period: DIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles. frame_start repeats every period.
- Transition edges: the anode never changes directly from one low bit to another while BLANK_CYCLES>0.
- Input-to-pin latency for a display change: up to one frame period plus one cycle.

## Structure
- types_pkg: DIGITS and byte_t (existing). Add scan_state_t enum {BLANK, DRIVE}.
- Single module. The one-hot anode decode and counter stay inline; no sub-module is warranted.
- Elaboration-time assertions: DWELL_CYCLES ≥1, BLANK_CYCLES ≥0, DIGITS ≥1.

## Test plan
Bench parameters: DIGITS=4, DWELL=3, BLANK=2, unless noted.
- Reset: rst=0 for 3 cycles -> anode=4'b1111, cathode=8'hFF, frame_start=0 throughout.
- Basic scan: display=32'hA4_F9_C0_92, digit_en=4'hF, release reset -> frame_start at edge 1 only.
  - Edges 3–5: anode=4'b1110, cathode=8'h92.
  - Edges 6–7: all blank.
  - Edges 8–10: anode=4'b1101, cathode=8'hC0.
  - Next frame_start at edge 21.
- Snapshot: change display to 32'hFFFF_FF80 at edge 4 -> digit 0 keeps 8'h92 until edge 21; shows 8'h80 from edge 23.
- Disable: digit_en=4'b1011 -> anode stays 4'b1111 during digit 2's slot; slot timing unchanged.
- Zero blank: BLANK=0 -> anode steps 1110→1101→1011→0111 every 3 cycles with no all-1 gap; frame_start every 12 cycles.
- Mid-frame reset: assert rst during digit 1's drive -> next edge gives anode=4'b1111, cathode=8'hFF. After release, scan restarts at digit 0 with a fresh frame_start.
